// File: rtl/alu_core.sv
// alu_core: registered ALU with split-operand wait state; defining ALU_MUL_EN adds the
// 3-cycle multiply path (arith cmds 12/13), otherwise those commands report err.
module alu_core #(
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  mode,
    input  logic [CMD_WIDTH-1:0]  cmd,
    input  logic [1:0]            inp_valid,
    input  logic [DATA_WIDTH-1:0] opa,
    input  logic [DATA_WIDTH-1:0] opb,
    input  logic                  cin,
    output logic [DATA_WIDTH+1:0] res,
    output logic                  cout,
    output logic                  oflow,
    output logic                  g,
    output logic                  l,
    output logic                  e,
    output logic                  err
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);
    localparam int OW = DATA_WIDTH + 8;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, WAIT_OP, MUL1, MUL2} state_t;
`else
    typedef enum logic {IDLE, WAIT_OP} state_t;
`endif

    state_t               state;
    logic [4:0]           cnt;
    logic [CMD_WIDTH-1:0] l_cmd;
    logic                 l_mode;
    logic [OW-1:0]        out_q;
    logic [OW-1:0]        exe;
    logic                 fire;

    logic [W-1:0]   x, lres, rol_v, ror_v;
    logic [W:0]     sum_v, dif_v, inc_v, dec_v;
    logic [W+1:0]   c_res;
    logic           c_cout, c_oflow, c_g, c_l, c_e, c_err;
    logic           need_a, need_b, bad_cmd, rot_bad, two_op;

`ifdef ALU_MUL_EN
    logic           is_mul;
    logic [W+1:0]   ma, mb, mp, prod;
    always_comb begin
        ma = cmd[0] ? {1'b0, opa, 1'b0} : {2'b0, opa} + (W+2)'(1);
        mb = cmd[0] ? {2'b0, opb} : {2'b0, opb} + (W+2)'(1);
        mp = ma * mb;
    end
`endif

    always_comb begin
        x       = cmd[1] ? opb : opa;
        sum_v   = {1'b0, opa} + {1'b0, opb} + {{W{1'b0}}, cmd[1] & cin};
        dif_v   = {1'b0, opa} - {1'b0, opb} - {{W{1'b0}}, cmd[1] & cin};
        inc_v   = {1'b0, x} + (W+1)'(1);
        dec_v   = {1'b0, x} - (W+1)'(1);
        rol_v   = (opa << opb[SW-1:0]) | (opa >> (W - int'(opb[SW-1:0])));
        ror_v   = (opa >> opb[SW-1:0]) | (opa << (W - int'(opb[SW-1:0])));
        c_res   = '0;
        lres    = '0;
        c_cout  = 1'b0;
        c_oflow = 1'b0;
        c_g     = 1'b0;
        c_l     = 1'b0;
        c_e     = 1'b0;
        need_a  = 1'b1;
        need_b  = 1'b1;
        bad_cmd = 1'b0;
        rot_bad = 1'b0;
`ifdef ALU_MUL_EN
        is_mul  = 1'b0;
`endif
        if (mode) begin
            case (int'(cmd))
                0, 2: begin c_res = {1'b0, sum_v}; c_cout = sum_v[W]; end
                1, 3: begin c_res = {2'b0, dif_v[W-1:0]}; c_oflow = dif_v[W]; end
                4, 6: begin need_a = ~cmd[1]; need_b = cmd[1]; c_res = {1'b0, inc_v}; c_cout = inc_v[W]; end
                5, 7: begin need_a = ~cmd[1]; need_b = cmd[1]; c_res = {2'b0, dec_v[W-1:0]}; c_oflow = dec_v[W]; end
                8: begin c_g = opa > opb; c_l = opa < opb; c_e = opa == opb; end
`ifdef ALU_MUL_EN
                12, 13: is_mul = 1'b1;
`endif
                default: bad_cmd = 1'b1;
            endcase
        end else begin
            case (int'(cmd))
                0: lres = opa & opb;
                1: lres = ~(opa & opb);
                2: lres = opa | opb;
                3: lres = ~(opa | opb);
                4: lres = opa ^ opb;
                5: lres = ~(opa ^ opb);
                6: begin need_b = 1'b0; lres = ~opa; end
                7: begin need_a = 1'b0; lres = ~opb; end
                8: begin need_b = 1'b0; lres = opa >> 1; end
                9: begin need_b = 1'b0; lres = opa << 1; end
                10: begin need_a = 1'b0; lres = opb >> 1; end
                11: begin need_a = 1'b0; lres = opb << 1; end
                12: begin lres = rol_v; rot_bad = |opb[W-1:SW]; end
                13: begin lres = ror_v; rot_bad = |opb[W-1:SW]; end
                default: bad_cmd = 1'b1;
            endcase
            c_res = {2'b0, lres};
        end
        c_err  = bad_cmd | rot_bad | (inp_valid == 2'b00) | (need_a & ~inp_valid[0]) | (need_b & ~inp_valid[1]);
        two_op = need_a & need_b & ~bad_cmd;
    end

    // A two-operand command with only one operand valid parks in WAIT_OP instead of executing
    assign fire = (state == IDLE) ? !(two_op && ^inp_valid)
                : (state == WAIT_OP) && inp_valid == 2'b11 && cmd == l_cmd && mode == l_mode;
    assign exe  = c_err ? OW'(1) : {c_res, c_cout, c_oflow, c_g, c_l, c_e, 1'b0};
    assign {res, cout, oflow, g, l, e, err} = out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            out_q  <= '0;
            l_cmd  <= '0;
            l_mode <= 1'b0;
`ifdef ALU_MUL_EN
            prod   <= '0;
`endif
        end else if (ce) begin
            if (fire) begin
                cnt <= '0;
`ifdef ALU_MUL_EN
                if (is_mul && !c_err) begin
                    prod  <= mp;
                    state <= MUL1;
                end else
`endif
                begin
                    out_q <= exe;
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state  <= WAIT_OP;
                        l_cmd  <= cmd;
                        l_mode <= mode;
                        cnt    <= 5'd16;
                    end
                    WAIT_OP: begin
                        if (inp_valid == 2'b11 || (inp_valid == 2'b00 && cnt == 5'd1)) begin
                            out_q <= OW'(1);
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= (inp_valid == 2'b00) ? cnt - 5'd1 : 5'd16;
                        end
                    end
`ifdef ALU_MUL_EN
                    MUL1: state <= MUL2;
                    MUL2: begin
                        out_q <= {prod, 6'b0};
                        state <= IDLE;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
